// File: rtl/jtdsp16_sdeser.sv
// jtdsp16_sdeser
// Serial output deserializer for the JTDSP16 serial port. It watches the DSP16
// serial output pins and rebuilds each 16-bit word together with the 8-bit
// serial address that travels alongside it. Words are then sorted into left
// and right audio sample registers by address. It sits between the DSP16
// serial pins and the Q-Sound mixer, and also serves as the bench monitor for
// the serial transmitter.
//
// Parameters
//   LEFT_ADDR   serial address that selects the left sample register
//   RIGHT_ADDR  serial address that selects the right sample register
//
// Ports
//   clk     in   system clock
//   rst     in   asynchronous, active-high reset
//   cen     in   sampling enable; state only advances on cycles with cen=1
//   ock     in   serial output clock from the DSP (data changes on its rise)
//   sdi     in   serial data, MSB first, sampled on falling ock
//   old     in   output load, active low; low while a frame is in progress
//   sadd    in   serial address bit, MSB first, valid for the first 8 bits
//   dout    out  last complete word
//   addr    out  address captured with dout
//   dvalid  out  one-clk pulse when dout/addr update
//   left    out  last word received with addr == LEFT_ADDR
//   right   out  last word received with addr == RIGHT_ADDR
//   sample  out  one-clk pulse when right updates (stereo pair complete)
//   err     out  one-clk pulse on a truncated frame

module jtdsp16_sdeser #(
  parameter logic [7:0] LEFT_ADDR  = 8'h00,
  parameter logic [7:0] RIGHT_ADDR = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        ock,
  input  logic        sdi,
  input  logic        old,
  input  logic        sadd,
  output logic [15:0] dout,
  output logic [7:0]  addr,
  output logic        dvalid,
  output logic [15:0] left,
  output logic [15:0] right,
  output logic        sample,
  output logic        err
);

  typedef enum logic {
    IDLE = 1'b0,
    RX   = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        ock_l;
  logic        fedge;
  logic [15:0] sh;
  logic [15:0] sh_nx;
  logic [7:0]  ash;
  logic [4:0]  bcnt;

  logic        take_bit;
  logic        word_done;
  logic        abort;
  logic        trunc;

  // ock_l only follows ock on enabled cycles, so toggles of ock while cen is
  // low are invisible. Resetting it to 0 means no edge is seen right after
  // reset even if ock is already low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ock_l <= 1'b0;
    end else if (cen) begin
      ock_l <= ock;
    end
  end

  assign fedge = cen && ock_l && !ock;
  assign sh_nx = {sh[14:0], sdi};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic. A frame starts on the first falling edge seen with old
  // low; old going high on any enabled cycle ends it.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (fedge && !old) begin
          state_nx = RX;
        end
      end
      RX: begin
        if (cen && old) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath controls. In RX, old has priority over a coincident falling
  // edge: the bit is dropped and the truncation rule applies instead.
  // bcnt==0 in RX means the previous word just finished cleanly, so leaving
  // the frame there is not an error.
  always_comb begin
    take_bit  = 1'b0;
    word_done = 1'b0;
    abort     = 1'b0;
    trunc     = 1'b0;
    case (state)
      IDLE: begin
        take_bit = fedge && !old;
      end
      RX: begin
        if (cen && old) begin
          abort = 1'b1;
          trunc = (bcnt != 5'd0);
        end else if (fedge) begin
          take_bit  = 1'b1;
          word_done = (bcnt == 5'd15);
        end
      end
      default: begin
        take_bit = 1'b0;
      end
    endcase
  end

  // Shift registers, bit counter and registered outputs. The pulse outputs
  // default low every clk, not just every cen cycle, so they last exactly one
  // clk. IDLE always has bcnt==0, so the first bit of a word goes through the
  // same shift path as every other bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh     <= 16'h0000;
      ash    <= 8'h00;
      bcnt   <= 5'd0;
      dout   <= 16'h0000;
      addr   <= 8'h00;
      left   <= 16'h0000;
      right  <= 16'h0000;
      dvalid <= 1'b0;
      sample <= 1'b0;
      err    <= 1'b0;
    end else begin
      dvalid <= 1'b0;
      sample <= 1'b0;
      err    <= 1'b0;
      if (abort) begin
        bcnt <= 5'd0;
        if (trunc) begin
          sh  <= 16'h0000;
          ash <= 8'h00;
          err <= 1'b1;
        end
      end else if (take_bit) begin
        sh <= sh_nx;
        if (bcnt < 5'd8) begin
          ash <= {ash[6:0], sadd};
        end
        if (word_done) begin
          // ash is complete after bit 8, so it is stable by the 16th bit.
          bcnt   <= 5'd0;
          dout   <= sh_nx;
          addr   <= ash;
          dvalid <= 1'b1;
          if (ash == LEFT_ADDR) begin
            left <= sh_nx;
          end
          if (ash == RIGHT_ADDR) begin
            right  <= sh_nx;
            sample <= 1'b1;
          end
        end else begin
          bcnt <= bcnt + 5'd1;
        end
      end
    end
  end

endmodule
